// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Launches from IDLE, holds busy for a fixed cycle count, then commits HI/LO with a done pulse.
module mdu_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hiwe,
  input  logic        lowe,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy_n, done_n;
  logic [31:0]        hi_n, lo_n;
  logic               launch;

  logic [1:0]         op_p0;
  logic [31:0]        a_p0, b_p0;
  logic [63:0]        mul_res, div_res, res;
  logic               div_zero;

  // Full 64-bit product; sign-extend operands for mult, zero-extend for multu.
  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, p;
    sx = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    sy = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    p  = sx * sy;
    return p;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // 0x80000000 / -1 case falls out naturally as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div64(input logic sgn, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] mx, my, q, r;
    logic        nx, ny;
    nx = sgn & x[31];
    ny = sgn & y[31];
    mx = nx ? -x : x;
    my = ny ? -y : y;
    q  = mx / my;
    r  = mx % my;
    if (nx ^ ny) q = -q;
    if (nx)      r = -r;
    return {r, q};
  endfunction

  // Stage p0: operands and opcode captured at the launch edge.
  always_ff @(posedge clk) begin
    if (launch) begin
      op_p0 <= mdop;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  assign mul_res  = mul64(~op_p0[0], a_p0, b_p0);
  assign div_res  = div64(~op_p0[0], a_p0, b_p0);
  assign res      = op_p0[1] ? div_res : mul_res;
  assign div_zero = op_p0[1] && (b_p0 == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_n = RUN;
          busy_n  = 1'b1;
          cnt_n   = mdop[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else begin
          if (hiwe) hi_n = wdata;
          if (lowe) lo_n = wdata;
        end
      end
      RUN: begin
        if (cnt > CNT_W'(1)) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          // A zero divisor still takes the full latency but leaves HI/LO alone.
          if (!div_zero) begin
            hi_n = res[63:32];
            lo_n = res[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
